// File: rtl/sd_card_pkg.sv
// Shared definitions for the SD-card SPI-mode command path: command indices,
// R1 response codes, initialisation error causes and CMD8/ACMD41 arguments.
package sd_card_pkg;

  typedef enum logic [2:0] {
    CMD_0      = 3'd0,
    CMD_8      = 3'd1,
    CMD_55     = 3'd2,
    CMD_ACMD41 = 3'd3,
    CMD_16     = 3'd4,
    CMD_17     = 3'd5,
    CMD_24     = 3'd6
  } cmd_sel_e;

  localparam logic [7:0] R1_READY   = 8'h00;
  localparam logic [7:0] R1_IDLE    = 8'h01;
  localparam logic [7:0] R1_ILLEGAL = 8'h05;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_CMD0    = 3'd1,
    ERR_CMD8    = 3'd2,
    ERR_ACMD41  = 3'd3,
    ERR_RETRY   = 3'd4,
    ERR_CMD16   = 3'd5,
    ERR_TIMEOUT = 3'd6
  } err_code_e;

  localparam logic [31:0] CMD8_ARG   = 32'h0000_01AA;
  localparam logic [31:0] ACMD41_HCS = 32'h4000_0000;

  // Width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sd_card_timeout.sv
// Loadable down-counter that stops at zero; o_expired is high while it reads zero.
module sd_card_timeout #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/sd_card_init_ctrl.sv
// SD-card SPI-mode initialisation sequencer: dummy clocks, CMD0/CMD8/CMD55/ACMD41/CMD16
// through a shared send/wait handshake, with response timeout, bounded restarts and error code.
module sd_card_init_ctrl
  import sd_card_pkg::*;
#(
  parameter int DUMMY_CLKS   = 80,
  parameter int ACMD41_RETRY = 1000,
  parameter int RESP_TIMEOUT = 4096,
  parameter int MAX_RESTART  = 2,
  parameter int BLOCK_LEN    = 512
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_sd_cs,
  output logic        o_dummy_en,
  output logic        o_send_cmd,
  output logic [2:0]  o_cmd_select,
  output logic [31:0] o_cmd_arg,
  input  logic        i_confirm_pin,
  input  logic [7:0]  i_response_status,
  output logic        o_init_finished,
  output logic        o_card_v2,
  output logic        o_busy,
  output logic        o_error,
  output logic [2:0]  o_err_code
);

  localparam int TW = (cnt_w(DUMMY_CLKS) > cnt_w(RESP_TIMEOUT)) ? cnt_w(DUMMY_CLKS) : cnt_w(RESP_TIMEOUT);
  localparam int AW = cnt_w(ACMD41_RETRY);
  localparam int RW = cnt_w(MAX_RESTART);
  localparam logic [TW-1:0] DUMMY_LOAD  = TW'(DUMMY_CLKS - 1);
  localparam logic [TW-1:0] RESP_LOAD   = TW'(RESP_TIMEOUT - 1);
  localparam logic [AW-1:0] ACMD_LAST   = AW'(ACMD41_RETRY - 1);
  localparam logic [RW-1:0] RESTART_MAX = RW'(MAX_RESTART);

  typedef enum logic [3:0] {
    ST_IDLE, ST_POWERUP, ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD16,
    ST_SEND, ST_WAIT, ST_FAIL, ST_DONE, ST_ERROR
  } state_e;

  state_e        r_state;
  cmd_sel_e      r_cmd_select;
  logic [31:0]   r_cmd_arg;
  logic          r_sd_cs, r_dummy_en, r_send_cmd, r_init_finished, r_card_v2, r_busy, r_error;
  err_code_e     r_err_code, r_fail_code;
  logic [AW-1:0] r_acmd_cnt;
  logic [RW-1:0] r_restart_cnt;

  cmd_sel_e      w_cmd_sel;
  logic [31:0]   w_cmd_arg;
  logic          w_is_cmd_state, w_start_ok, w_tmo_load, w_tmo_en, w_tmo_expired;
  logic [TW-1:0] w_tmo_val;

  always_comb begin
    w_is_cmd_state = 1'b1;
    w_cmd_sel      = CMD_0;
    w_cmd_arg      = '0;
    case (r_state)
      ST_CMD0:   ;
      ST_CMD8:   begin w_cmd_sel = CMD_8;      w_cmd_arg = CMD8_ARG; end
      ST_CMD55:  w_cmd_sel = CMD_55;
      ST_ACMD41: begin w_cmd_sel = CMD_ACMD41; w_cmd_arg = r_card_v2 ? ACMD41_HCS : '0; end
      ST_CMD16:  begin w_cmd_sel = CMD_16;     w_cmd_arg = 32'(BLOCK_LEN); end
      default:   w_is_cmd_state = 1'b0;
    endcase
  end

  // One counter serves both the dummy-clock window and the per-command response wait.
  assign w_start_ok = i_start && (r_state inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign w_tmo_load = w_start_ok || w_is_cmd_state || ((r_state == ST_FAIL) && (r_restart_cnt < RESTART_MAX));
  assign w_tmo_val  = w_is_cmd_state ? RESP_LOAD : DUMMY_LOAD;
  assign w_tmo_en   = (r_state == ST_POWERUP) || (r_state == ST_WAIT);

  sd_card_timeout #(.W(TW)) u_timeout (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmo_load),
    .i_load_val (w_tmo_val),
    .i_en       (w_tmo_en),
    .o_expired  (w_tmo_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= ST_IDLE;
      r_cmd_select    <= CMD_0;
      r_cmd_arg       <= '0;
      r_sd_cs         <= 1'b1;
      r_dummy_en      <= 1'b0;
      r_send_cmd      <= 1'b0;
      r_init_finished <= 1'b0;
      r_card_v2       <= 1'b0;
      r_busy          <= 1'b0;
      r_error         <= 1'b0;
      r_err_code      <= ERR_NONE;
      r_fail_code     <= ERR_NONE;
      r_acmd_cnt      <= '0;
      r_restart_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: if (i_start) begin
          r_state         <= ST_POWERUP;
          r_sd_cs         <= 1'b1;
          r_dummy_en      <= 1'b1;
          r_busy          <= 1'b1;
          r_restart_cnt   <= '0;
          r_acmd_cnt      <= '0;
          r_card_v2       <= 1'b0;
          r_error         <= 1'b0;
          r_err_code      <= ERR_NONE;
          r_init_finished <= 1'b0;
        end
        ST_POWERUP: if (w_tmo_expired) begin
          r_dummy_en <= 1'b0;
          r_state    <= ST_CMD0;
        end
        ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD16: begin
          r_cmd_select <= w_cmd_sel;
          r_cmd_arg    <= w_cmd_arg;
          r_send_cmd   <= 1'b1;
          r_sd_cs      <= 1'b0;
          r_state      <= ST_SEND;
        end
        ST_SEND: begin
          r_send_cmd <= 1'b0;
          r_state    <= ST_WAIT;
        end
        // A confirm on the expiry cycle is still taken as a response.
        ST_WAIT: if (i_confirm_pin) begin
          case (r_cmd_select)
            CMD_8: if (i_response_status == R1_IDLE) begin
              r_card_v2 <= 1'b1;
              r_state   <= ST_CMD55;
            end else if (i_response_status == R1_ILLEGAL) begin
              r_card_v2 <= 1'b0;
              r_state   <= ST_CMD55;
            end else begin
              r_fail_code <= ERR_CMD8;
              r_state     <= ST_FAIL;
            end
            CMD_55: if ((i_response_status == R1_IDLE) || (i_response_status == R1_READY)) begin
              r_state <= ST_ACMD41;
            end else begin
              r_fail_code <= ERR_ACMD41;
              r_state     <= ST_FAIL;
            end
            CMD_ACMD41: if (i_response_status == R1_READY) begin
              if (r_card_v2) begin
                r_init_finished <= 1'b1;
                r_sd_cs         <= 1'b1;
                r_busy          <= 1'b0;
                r_state         <= ST_DONE;
              end else begin
                r_state <= ST_CMD16;
              end
            end else if (i_response_status == R1_IDLE) begin
              r_acmd_cnt <= r_acmd_cnt + 1'b1;
              if (r_acmd_cnt >= ACMD_LAST) begin
                r_fail_code <= ERR_RETRY;
                r_state     <= ST_FAIL;
              end else begin
                r_state <= ST_CMD55;
              end
            end else begin
              r_fail_code <= ERR_ACMD41;
              r_state     <= ST_FAIL;
            end
            CMD_16: if (i_response_status == R1_READY) begin
              r_init_finished <= 1'b1;
              r_sd_cs         <= 1'b1;
              r_busy          <= 1'b0;
              r_state         <= ST_DONE;
            end else begin
              r_fail_code <= ERR_CMD16;
              r_state     <= ST_FAIL;
            end
            default: if (i_response_status == R1_IDLE) begin
              r_state <= ST_CMD8;
            end else begin
              r_fail_code <= ERR_CMD0;
              r_state     <= ST_FAIL;
            end
          endcase
        end else if (w_tmo_expired) begin
          r_fail_code <= ERR_TIMEOUT;
          r_state     <= ST_FAIL;
        end
        ST_FAIL: if (r_restart_cnt < RESTART_MAX) begin
          r_restart_cnt <= r_restart_cnt + 1'b1;
          r_acmd_cnt    <= '0;
          r_card_v2     <= 1'b0;
          r_sd_cs       <= 1'b1;
          r_dummy_en    <= 1'b1;
          r_state       <= ST_POWERUP;
        end else begin
          r_error    <= 1'b1;
          r_err_code <= r_fail_code;
          r_sd_cs    <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_ERROR;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_sd_cs         = r_sd_cs;
  assign o_dummy_en      = r_dummy_en;
  assign o_send_cmd      = r_send_cmd;
  assign o_cmd_select    = r_cmd_select;
  assign o_cmd_arg       = r_cmd_arg;
  assign o_init_finished = r_init_finished;
  assign o_card_v2       = r_card_v2;
  assign o_busy          = r_busy;
  assign o_error         = r_error;
  assign o_err_code      = r_err_code;

endmodule
